// File: rtl/kmeans_result_tx_if.sv
// Output word stream of the k-means result transmitter: valid/ready with end-of-frame marker.
interface kmeans_result_tx_if #(
   parameter int PIX_W = 24
);
   logic             valid;
   logic             ready;
   logic             last;
   logic [PIX_W-1:0] data;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/kmeans_result_tx.sv
// Streams a clustering result frame: header, K mean colours, then one quantized pixel per label.
//
// state | meaning
// IDLE  | waiting for start; FIFO empty
// HDR   | header word buffered, waiting for it to be accepted
// MEANS | mean words being accepted
// PIX   | label reads feeding quantized pixels through the FIFO
// DONE  | one-cycle done pulse, then back to IDLE
module kmeans_result_tx #(
   parameter int K      = 16,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            k_count,
   input  logic [ADDR_W:0]       image_size,
   input  logic [K*PIX_W-1:0]    means,
   output logic                  lbl_rd_en,
   output logic [ADDR_W-1:0]     lbl_addr,
   input  logic [IDX_W-1:0]      lbl_data,
   kmeans_result_tx_if.master    out_if,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, HDR, MEANS, PIX, DONE} state_t;
   state_t state, state_nx;

   logic [PIX_W-1:0]  means_r [K];
   logic [7:0]        k_r, gen_mean, acc_mean;
   logic [ADDR_W:0]   size_r, gen_addr;
   logic [1:0]        cnt;
   logic [PIX_W-1:0]  f0_data, f1_data;
   logic              f0_last, f1_last;
   logic              rd_pend, pend_last;
   logic [ADDR_W-1:0] addr_hold;

   logic              pop, push, push_last;
   logic [PIX_W-1:0]  push_data, hdr_word, lbl_word;
   logic [2:0]        occ;
   logic              producing, credit_ok, mean_push, rd_issue, start_acc;
   logic [15:0]       size16;

   assign start_acc = (state == IDLE) && start;
   assign pop       = (cnt != 2'd0) && out_if.ready;
   // A word leaving this cycle frees its slot before any newly issued read can return,
   // which is what lets the pixel phase reach one word per cycle.
   assign occ       = 3'(cnt) + 3'(rd_pend) - 3'(pop);
   assign credit_ok = occ < 3'd2;
   assign producing = (state == HDR) || (state == MEANS) || (state == PIX);
   assign mean_push = producing && (gen_mean < k_r) && credit_ok;
   assign rd_issue  = producing && (gen_mean >= k_r) && (gen_addr < size_r) && credit_ok;

   assign size16    = 16'(image_size);
   assign hdr_word  = PIX_W'({k_count, size16});
   assign lbl_word  = (8'(lbl_data) < k_r) ? means_r[lbl_data] : '0;

   assign lbl_rd_en = rd_issue;
   assign lbl_addr  = rd_issue ? gen_addr[ADDR_W-1:0] : addr_hold;

   assign out_if.valid = (cnt != 2'd0);
   assign out_if.data  = f0_data;
   assign out_if.last  = f0_last;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Select the single word entering the FIFO this cycle; the three sources never overlap.
   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_last = 1'b0;
      if (start_acc) begin
         push      = 1'b1;
         push_data = hdr_word;
      end else if (mean_push) begin
         push      = 1'b1;
         push_data = means_r[gen_mean[IDX_W-1:0]];
         push_last = (size_r == '0) && (gen_mean == k_r - 8'd1);
      end else if (rd_pend) begin
         push      = 1'b1;
         push_data = lbl_word;
         push_last = pend_last;
      end
   end

   // Two-entry FIFO; f0 is the head and drives the output port directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 2'd0;
         f0_data <= '0;
         f1_data <= '0;
         f0_last <= 1'b0;
         f1_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  f0_data <= push_data;
                  f0_last <= push_last;
               end else begin
                  f1_data <= push_data;
                  f1_last <= push_last;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               f0_data <= f1_data;
               f0_last <= f1_last;
               cnt     <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  f0_data <= push_data;
                  f0_last <= push_last;
               end else begin
                  f0_data <= f1_data;
                  f0_last <= f1_last;
                  f1_data <= push_data;
                  f1_last <= push_last;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame parameters, mean snapshot and producer counters for means and label reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_r       <= 8'd0;
         size_r    <= '0;
         gen_mean  <= 8'd0;
         gen_addr  <= '0;
         rd_pend   <= 1'b0;
         pend_last <= 1'b0;
         addr_hold <= '0;
         for (int j = 0; j < K; j++) means_r[j] <= '0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            pend_last <= (gen_addr == size_r - (ADDR_W+1)'(1));
            gen_addr  <= gen_addr + (ADDR_W+1)'(1);
            addr_hold <= gen_addr[ADDR_W-1:0];
         end
         if (mean_push) gen_mean <= gen_mean + 8'd1;
         if (start_acc) begin
            k_r      <= k_count;
            size_r   <= image_size;
            gen_mean <= 8'd0;
            gen_addr <= '0;
            for (int j = 0; j < K; j++) means_r[j] <= means[j*PIX_W +: PIX_W];
         end
      end
   end

   // State register and count of mean words accepted by the sink.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc_mean <= 8'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE)             acc_mean <= 8'd0;
         else if (state == MEANS && pop) acc_mean <= acc_mean + 8'd1;
      end
   end

   // Phase advances follow words accepted at the output, not words produced.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = HDR;
         HDR:   if (pop) state_nx = MEANS;
         MEANS: begin
            if (pop && f0_last)                      state_nx = DONE;
            else if (pop && acc_mean == k_r - 8'd1)  state_nx = PIX;
         end
         PIX:   if (pop && f0_last) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_kmeans_result_tx.sv
// Scoreboard bench for kmeans_result_tx: expected frame words queued at start, compared on transfer.
module tb_kmeans_result_tx;
   localparam int K      = 16;
   localparam int IDX_W  = 4;
   localparam int ADDR_W = 12;
   localparam int PIX_W  = 24;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [7:0]           k_count = 8'd0;
   logic [ADDR_W:0]      image_size = '0;
   logic [K*PIX_W-1:0]   means = '0;
   logic                 lbl_rd_en;
   logic [ADDR_W-1:0]    lbl_addr;
   logic [IDX_W-1:0]     lbl_data;
   logic                 busy, done;

   kmeans_result_tx_if #(.PIX_W(PIX_W)) oif ();

   kmeans_result_tx #(.K(K), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
      .clk(clk), .reset(reset), .start(start), .k_count(k_count), .image_size(image_size),
      .means(means), .lbl_rd_en(lbl_rd_en), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
      .out_if(oif), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [IDX_W-1:0] lmem [1 << ADDR_W];
   logic [PIX_W-1:0] mref [K];
   logic [PIX_W:0]   exp_q [$];

   int n_vec = 0, n_err = 0;
   int n_done = 0, n_rd = 0, last_addr = -1;
   int cyc = 0, word_idx = 0, pix_start = 0, first_pix_cyc = 0, last_cyc = 0;
   int rdy_mode = 0;
   logic           prev_stall = 1'b0;
   logic [PIX_W:0] prev_word = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Label memory model: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (lbl_rd_en) begin
         lbl_data  <= lmem[lbl_addr];
         n_rd      <= n_rd + 1;
         last_addr <= int'(lbl_addr);
      end
      if (!reset && done) n_done <= n_done + 1;
   end

   // Sink-ready pattern generator.
   initial begin
      int ph = 0;
      oif.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: oif.ready = 1'b1;
            1: oif.ready = (ph % 4 == 0) || (ph % 4 == 3);
            default: oif.ready = 1'b0;
         endcase
         ph++;
      end
   end

   // Output monitor: scoreboard compare on transfer, stability check while stalled.
   always @(negedge clk) begin
      logic [PIX_W:0] e;
      cyc++;
      if (!reset) begin
         if (prev_stall)
            check("stall_stable", {6'd0, oif.valid, oif.last, oif.data}, {6'd0, 1'b1, prev_word});
         if (oif.valid && oif.ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word_count", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("word", {7'd0, oif.last, oif.data}, {7'd0, e});
            end
            if (word_idx == pix_start) first_pix_cyc = cyc;
            last_cyc = cyc;
            word_idx++;
         end
         prev_stall = oif.valid && !oif.ready;
         prev_word  = {oif.last, oif.data};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic load_means(input int k);
      means = '0;
      for (int j = 0; j < k; j++) means[j*PIX_W +: PIX_W] = mref[j];
   endtask

   task automatic pulse_start(input int k, input int sz);
      @(posedge clk);
      #1;
      start      = 1'b1;
      k_count    = 8'(k);
      image_size = (ADDR_W+1)'(sz);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic queue_frame(input int k, input int sz);
      int lbl;
      exp_q.push_back({1'b0, 8'(k), 16'(sz)});
      for (int j = 0; j < k; j++) exp_q.push_back({(sz == 0) && (j == k - 1), mref[j]});
      for (int a = 0; a < sz; a++) begin
         lbl = int'(lmem[a]);
         exp_q.push_back({a == sz - 1, (lbl < k) ? mref[lbl] : 24'h000000});
      end
   endtask

   task automatic run_frame(input int k, input int sz, input int mode, input bit scramble,
                            input bit poke_start);
      bit seen = 1'b0;
      rdy_mode = mode;
      load_means(k);
      queue_frame(k, sz);
      n_done    = 0;
      n_rd      = 0;
      word_idx  = 0;
      pix_start = k + 1;
      pulse_start(k, sz);
      check("hdr_valid_latency", {31'd0, oif.valid}, 32'd1);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      if (scramble) means = ~means;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clk);
         if (poke_start && i == 6) begin
            start = 1'b1;
            k_count = 8'd7;
            image_size = (ADDR_W+1)'(1);
         end else begin
            start = 1'b0;
         end
         seen = done;
      end
      start = 1'b0;
      check("done_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      check("done_single_pulse", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("done_count", 32'(n_done), 32'd1);
      check("read_count", 32'(n_rd), 32'(sz));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (sz > 0) check("last_read_addr", 32'(last_addr), 32'(sz - 1));
      if (mode == 0 && sz > 1) check("pixel_throughput", 32'(last_cyc - first_pix_cyc), 32'(sz - 1));
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) lmem[a] = '0;
      for (int j = 0; j < K; j++) mref[j] = '0;
      #1;
      check("rst_valid", {31'd0, oif.valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_en", {31'd0, lbl_rd_en}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // basic frame
      mref[0] = 24'hFF0000; mref[1] = 24'h00FF00;
      lmem[0] = 4'd1; lmem[1] = 4'd0; lmem[2] = 4'd1;
      run_frame(2, 3, 0, 1'b0, 1'b0);

      // backpressure plus ignored start while busy
      run_frame(2, 3, 1, 1'b0, 1'b1);

      // empty image
      mref[2] = 24'h0000FF;
      run_frame(3, 0, 0, 1'b0, 1'b0);

      // snapshot and out-of-range labels
      mref[0] = 24'h123456; mref[1] = 24'hABCDEF; mref[2] = 24'h0F0F0F; mref[3] = 24'hC0FFEE;
      lmem[0] = 4'd5; lmem[1] = 4'd2; lmem[2] = 4'd0; lmem[3] = 4'd3; lmem[4] = 4'd5; lmem[5] = 4'd1;
      run_frame(4, 6, 1, 1'b1, 1'b0);

      // full size, single cluster
      for (int a = 0; a < (1 << ADDR_W); a++) lmem[a] = '0;
      mref[0] = 24'h5A5A5A;
      run_frame(1, 1 << ADDR_W, 0, 1'b0, 1'b0);

      // reset in the pixel phase with the FIFO backed up
      for (int a = 0; a < 20; a++) lmem[a] = 4'(a % 2);
      mref[1] = 24'h777777;
      rdy_mode = 0;
      load_means(2);
      queue_frame(2, 20);
      n_done = 0;
      word_idx = 0;
      pix_start = 3;
      pulse_start(2, 20);
      repeat (8) @(negedge clk);
      rdy_mode = 2;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_valid", {31'd0, oif.valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      repeat (4) @(negedge clk);
      check("abort_no_done", 32'(n_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      mref[0] = 24'hFF0000; mref[1] = 24'h00FF00;
      lmem[0] = 4'd1; lmem[1] = 4'd0; lmem[2] = 4'd1;
      run_frame(2, 3, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
